// File: rtl/div_arbiter_if.sv
// Purpose: bus between the divide arbiter and the shared iterative divider.
// Latency: wires only; no storage of its own.
// Backpressure: the divider holds off completion by keeping div_ready low.
interface div_arbiter_if #(
  parameter int WIDTH = 32
) ();
  logic               div_start;
  logic               div_signed;
  logic [WIDTH-1:0]   div_opa;
  logic [WIDTH-1:0]   div_opb;
  logic               div_annul;
  logic [2*WIDTH-1:0] div_result;
  logic               div_ready;

  // Arbiter side: issues operations, consumes results.
  modport master (
    output div_start, div_signed, div_opa, div_opb, div_annul,
    input  div_result, div_ready
  );

  // Divider side: accepts operations, returns results.
  modport slave (
    input  div_start, div_signed, div_opa, div_opb, div_annul,
    output div_result, div_ready
  );
endinterface

// File: rtl/div_arbiter.sv
// Purpose: shares one iterative divider between master and slave issue pipes.
// Latency: start 1 cycle after an accepted request; done 1 cycle after div_ready.
// Backpressure: stall_div freezes both pipes until every divide in the bundle completes.
module div_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req0,
  input  logic               signed0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic               signed1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  div_arbiter_if.master      dv,
  output logic               stall_div,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result0,
  output logic [2*WIDTH-1:0] result1
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             owner;      // 0 = master pipe, 1 = slave pipe
  logic             served0;    // master divide of the current bundle finished
  logic             served1;    // slave divide of the current bundle finished
  logic             start_q;
  logic             signed_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             elig0;
  logic             elig1;

  assign elig0 = req0 & ~served0;
  assign elig1 = req1 & ~served1;

  assign dv.div_start  = start_q;
  assign dv.div_signed = signed_q;
  assign dv.div_opa    = opa_q;
  assign dv.div_opb    = opb_q;
  // Kill the divider only when it is actually working on something.
  assign dv.div_annul  = ~rst & flush & (state == RUN);

  // Hold the bundle while a divide runs or the other pipe still needs the divider.
  always_comb begin
    stall_div = 1'b0;
    if (!rst && !flush) begin
      case (state)
        IDLE:    stall_div = elig0 | elig1;
        RUN:     stall_div = 1'b1;
        DONE:    stall_div = owner ? elig0 : elig1;
        default: stall_div = 1'b0;
      endcase
    end
  end

  // Arbitration FSM with registered divider controls, done pulses and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      served0  <= 1'b0;
      served1  <= 1'b0;
      start_q  <= 1'b0;
      signed_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      result0  <= '0;
      result1  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      // Bundle advances: any request seen from now on is a new instruction.
      if (!stall_div) begin
        served0 <= 1'b0;
        served1 <= 1'b0;
      end
      if (flush) begin
        state   <= IDLE;
        start_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (elig0) begin
              owner    <= 1'b0;
              opa_q    <= a0;
              opb_q    <= b0;
              signed_q <= signed0;
              start_q  <= 1'b1;
              state    <= RUN;
            end else if (elig1) begin
              owner    <= 1'b1;
              opa_q    <= a1;
              opb_q    <= b1;
              signed_q <= signed1;
              start_q  <= 1'b1;
              state    <= RUN;
            end
          end
          RUN: begin
            if (dv.div_ready) begin
              if (owner) begin
                result1 <= dv.div_result;
                done1   <= 1'b1;
              end else begin
                result0 <= dv.div_result;
                done0   <= 1'b1;
              end
              start_q <= 1'b0;
              state   <= DONE;
            end
          end
          DONE: begin
            // Remember the finished pipe only while the bundle is still held.
            if (stall_div) begin
              if (owner) served1 <= 1'b1;
              else       served0 <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares the single iterative divider between the master and slave issue pipes.
- Serialises DIV/DIVU requests from both pipes and drives the divider's start, signed and annul controls.
- Captures each 64-bit {hi,lo} result per pipe and generates the common stall_div that freezes the issue bundle until every divide in it has completed.
- Sits in execute, between the two ALUs and the div unit.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush; abandons all in-flight and pending divides
req0  in  1  master pipe divide request; held while stall_div=1
signed0  in  1  master: 1=DIV, 0=DIVU
a0  in  WIDTH  master dividend
b0  in  WIDTH  master divisor
req1  in  1  slave pipe divide request
signed1  in  1  slave: 1=DIV, 0=DIVU
a1  in  WIDTH  slave dividend
b1  in  WIDTH  slave divisor
div_start  out  1  to divider start_i
div_signed  out  1  to divider signed_div_i
div_opa  out  WIDTH  to divider opdata1_i
div_opb  out  WIDTH  to divider opdata2_i
div_annul  out  1  to divider annul_i
div_result  in  2*WIDTH  from divider result_o
div_ready  in  1  from divider ready_o
stall_div  out  1  freeze both pipes
done0  out  1  one-cycle pulse: master result valid
done1  out  1  one-cycle pulse: slave result valid
result0  out  2*WIDTH  master {hi,lo}; held until next master completion
result1  out  2*WIDTH  slave {hi,lo}; held until next slave completion

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; owner=0; served0=served1=0.
  - div_start, div_signed, div_opa, div_opb, done0, done1, result0 and result1 all 0.
  - div_annul=0 and stall_div=0 while rst is high.
  - rst has priority over flush.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE:
    - A requester is eligible when reqN=1 and servedN=0.
    - Fixed priority: master over slave.
    - On an eligible request: latch aN/bN/signedN into div_opa/div_opb/div_signed, set owner=N, go to RUN.
    - With no eligible request, stay in IDLE.
  - RUN:
    - div_start=1, held for the whole state; operands stay stable.
    - On div_ready=1: capture div_result into result[owner], drop div_start next cycle, go to DONE.
  - DONE:
    - done[owner]=1 for exactly this cycle.
    - served[owner] set at the end of the cycle.
    - Next state is IDLE.
- stall_div (combinational):
  - RUN: 1.
  - IDLE: 1 iff any eligible request exists.
  - DONE: 1 iff the other requester has req=1 and served=0; otherwise 0, so the bundle advances in the DONE cycle.
- served0 and served1 clear at any clock edge where stall_div=0. Requests seen after the bundle advances therefore belong to a new instruction.
- Latency, single request:
  - req at cycle 0 (IDLE); div_start at cycle 1.
  - If div_ready is seen at cycle k, then done and stall_div=0 occur at cycle k+1.
- Dual request: master runs to completion first; the slave starts in the IDLE cycle after the master's DONE. stall_div stays 1 continuously until the slave's DONE cycle.
- flush (synchronous, any state):
  - Next state IDLE; served0 and served1 cleared.
  - No done pulse is generated and result0/result1 are not updated.
  - div_annul = flush & (state==RUN), combinational; div_start=0 from the next cycle.
  - stall_div=0 during the flush cycle.
  - flush and div_ready in the same cycle: flush wins and the result is discarded.
- A request that drops while its divide is in RUN (without flush) is a protocol violation; the block still completes and pulses done.
- Divide-by-zero and signed correction are handled inside the divider; this block passes results through unchanged.

Test Plan:
1. Reset: rst=1 for 2 cycles with req0=1 -> all outputs 0, state IDLE. After release, div_start rises exactly 1 cycle after the first sampled req0.
2. Master only: req0=1, signed0=1, a0=-7 (0xFFFFFFF9), b0=2; divider model returns ready after 34 cycles with {hi=-1,lo=-3}.
   - Required: result0=0xFFFFFFFF_FFFFFFFD, done0 pulse of 1 cycle.
   - stall_div=1 from cycle 0 through the ready cycle, 0 in the DONE cycle; done1 stays 0.
3. Dual request: req0 (DIVU 100/7) and req1 (DIV 9/-2) in the same cycle.
   - Required: the master starts first and div_signed=0 for its run.
   - result0={2,14}, then a second div_start with div_signed=1, then result1={1,-4}.
   - stall_div stays high continuously until the slave's DONE cycle; there is no third start.
4. Slave only: req1=1, req0=0 -> owner=slave, done1 pulse, result0 unchanged from its previous value.
5. Flush mid-run: assert flush 10 cycles into RUN.
   - Required: div_annul=1 for that cycle; no done pulse; state IDLE next cycle.
   - result0/result1 unchanged; stall_div=0 in the flush cycle.
6. Flush coincident with div_ready: no done pulse, result not captured, served flags 0. Then a new req0 starts a fresh run.
